// File: rtl/pkt_buf_pkg.sv
// Shared types and widths for the packet cell client and its neighbours.
package pkt_buf_pkg;

  // Width of the free-running drop and allocation statistics counters.
  localparam int CNT_WIDTH = 32;

  // Allocation FSM: wait for a packet, request a cell, present the descriptor.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_OUT  = 2'd2
  } alloc_state_t;

  // Width needed to count from 0 up to and including cell_num.
  function automatic int occ_width(input int cell_num);
    return $clog2(cell_num) + 1;
  endfunction

endpackage

// File: rtl/axis_fifo.sv
// Small synchronous valid/ready FIFO; data is held stable at the head until popped.
module axis_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  assign s_ready = (count != CNT_W'(DEPTH));
  assign m_valid = (count != '0);
  assign m_data  = mem[rd_ptr];
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  // Storage array needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers wrap explicitly so non-power-of-two depths also work.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_cell_client.sv
// Per-packet cell allocation client with a buffered release path to the allocator.
module pkt_cell_client
  import pkt_buf_pkg::*;
#(
  parameter int LEN_WIDTH     = 16,
  parameter int CELL_NUM      = 64,
  parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
  parameter int CELL_BYTES    = 1536,
  parameter int ALLOC_TIMEOUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_pkt_valid,
  output logic                         s_pkt_ready,
  input  logic [LEN_WIDTH-1:0]         s_pkt_len,
  input  logic                         s_pkt_prio,
  output logic                         alloc_mem_req,
  output logic [LEN_WIDTH-1:0]         alloc_mem_size,
  input  logic [CELL_ID_WIDTH-1:0]     alloc_cell_id,
  input  logic                         alloc_mem_success,
  input  logic                         alloc_mem_intense,
  output logic                         m_desc_valid,
  input  logic                         m_desc_ready,
  output logic [CELL_ID_WIDTH-1:0]     m_desc_cell_id,
  output logic [LEN_WIDTH-1:0]         m_desc_len,
  input  logic                         s_rel_valid,
  output logic                         s_rel_ready,
  input  logic [CELL_ID_WIDTH-1:0]     s_rel_cell_id,
  input  logic [LEN_WIDTH-1:0]         s_rel_len,
  output logic                         free_mem_req,
  input  logic                         free_mem_ready,
  output logic [CELL_ID_WIDTH-1:0]     free_cell_id,
  output logic [LEN_WIDTH-1:0]         free_mem_size,
  output logic [CNT_WIDTH-1:0]         drop_cnt,
  output logic [CNT_WIDTH-1:0]         alloc_cnt,
  output logic [occ_width(CELL_NUM)-1:0] outstanding_cells
);

  localparam int OCC_W   = occ_width(CELL_NUM);
  localparam int RETRY_W = $clog2(ALLOC_TIMEOUT + 1);
  localparam int REL_W   = LEN_WIDTH + CELL_ID_WIDTH;
  localparam logic [LEN_WIDTH:0] MAX_LEN    = (LEN_WIDTH + 1)'(CELL_BYTES);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(ALLOC_TIMEOUT - 1);

  alloc_state_t           state_q, state_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   prio_q;
  logic [CELL_ID_WIDTH-1:0] cell_id_q;
  logic [CNT_WIDTH-1:0]   drop_q;
  logic [CNT_WIDTH-1:0]   alloc_q;
  logic [OCC_W-1:0]       occ_q;
  logic                   req_c;
  logic                   drop_evt;
  logic                   alloc_evt;
  logic                   pkt_accept;
  logic                   len_bad;
  logic                   free_hs;
  logic                   fifo_s_ready;
  logic                   fifo_m_valid;
  logic [REL_W-1:0]       fifo_m_data;

  // Every handshake/strobe output is forced low while reset is held.
  assign s_pkt_ready    = !rst && (state_q == ST_IDLE);
  assign alloc_mem_req  = !rst && req_c;
  assign alloc_mem_size = alloc_mem_req ? len_q : '0;
  assign m_desc_valid   = !rst && (state_q == ST_OUT);
  assign m_desc_cell_id = rst ? '0 : cell_id_q;
  assign m_desc_len     = rst ? '0 : len_q;
  assign drop_cnt       = rst ? '0 : drop_q;
  assign alloc_cnt      = rst ? '0 : alloc_q;
  assign outstanding_cells = rst ? '0 : occ_q;

  assign pkt_accept = s_pkt_valid && s_pkt_ready;
  assign len_bad    = (len_q == '0) || ({1'b0, len_q} > MAX_LEN);
  assign free_hs    = free_mem_req && free_mem_ready;

  // Allocation FSM state and retry counter; reset discards any in-flight packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; drop screening only happens on the first request cycle.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    req_c     = 1'b0;
    drop_evt  = 1'b0;
    alloc_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        retry_d = '0;
        if (pkt_accept) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if ((retry_q == '0) && (len_bad || (alloc_mem_intense && !prio_q))) begin
          drop_evt = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          req_c = 1'b1;
          if (alloc_mem_success) begin
            alloc_evt = 1'b1;
            retry_d   = '0;
            state_d   = ST_OUT;
          end else if (retry_q == RETRY_LAST) begin
            drop_evt = 1'b1;
            retry_d  = '0;
            state_d  = ST_IDLE;
          end else begin
            retry_d = retry_q + 1'b1;
          end
        end
      end
      ST_OUT: begin
        if (m_desc_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Packet descriptor capture and wrapping drop/alloc statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      prio_q    <= 1'b0;
      cell_id_q <= '0;
      drop_q    <= '0;
      alloc_q   <= '0;
    end else begin
      if (pkt_accept) begin
        len_q  <= s_pkt_len;
        prio_q <= s_pkt_prio;
      end
      if (alloc_evt) begin
        cell_id_q <= alloc_cell_id;
        alloc_q   <= alloc_q + 1'b1;
      end
      if (drop_evt) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  // Cells held by this client; a simultaneous alloc and free cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else if (alloc_evt && !free_hs) begin
      if (occ_q != OCC_W'(CELL_NUM)) begin
        occ_q <= occ_q + 1'b1;
      end
    end else if (free_hs && !alloc_evt) begin
      if (occ_q != '0) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  assign s_rel_ready   = !rst && fifo_s_ready;
  assign free_mem_req  = !rst && fifo_m_valid;
  assign free_cell_id  = rst ? '0 : fifo_m_data[CELL_ID_WIDTH-1:0];
  assign free_mem_size = rst ? '0 : fifo_m_data[REL_W-1:CELL_ID_WIDTH];

  axis_fifo #(
    .DEPTH      (4),
    .DATA_WIDTH (REL_W)
  ) u_rel_fifo (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_rel_valid && !rst),
    .s_ready (fifo_s_ready),
    .s_data  ({s_rel_len, s_rel_cell_id}),
    .m_valid (fifo_m_valid),
    .m_ready (free_mem_ready && !rst),
    .m_data  (fifo_m_data)
  );

endmodule

// File: tb/tb_pkt_cell_client.sv
// Randomised self-checking bench for pkt_cell_client against a transaction-level model.
module tb_pkt_cell_client;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_pkt_valid = 1'b0;
  logic        s_pkt_ready;
  logic [15:0] s_pkt_len = '0;
  logic        s_pkt_prio = 1'b0;
  logic        alloc_mem_req;
  logic [15:0] alloc_mem_size;
  logic [5:0]  alloc_cell_id = '0;
  logic        alloc_mem_success = 1'b0;
  logic        alloc_mem_intense = 1'b0;
  logic        m_desc_valid;
  logic        m_desc_ready = 1'b0;
  logic [5:0]  m_desc_cell_id;
  logic [15:0] m_desc_len;
  logic        s_rel_valid = 1'b0;
  logic        s_rel_ready;
  logic [5:0]  s_rel_cell_id = '0;
  logic [15:0] s_rel_len = '0;
  logic        free_mem_req;
  logic        free_mem_ready = 1'b0;
  logic [5:0]  free_cell_id;
  logic [15:0] free_mem_size;
  logic [31:0] drop_cnt;
  logic [31:0] alloc_cnt;
  logic [6:0]  outstanding_cells;

  int checks = 0;
  int failures = 0;

  // Model state: packet statistics, held cells and pending releases.
  int drop_m = 0;
  int alloc_m = 0;
  int occ_m = 0;
  logic [21:0] rel_q[$];

  pkt_cell_client dut (
    .clk(clk), .rst(rst),
    .s_pkt_valid(s_pkt_valid), .s_pkt_ready(s_pkt_ready),
    .s_pkt_len(s_pkt_len), .s_pkt_prio(s_pkt_prio),
    .alloc_mem_req(alloc_mem_req), .alloc_mem_size(alloc_mem_size),
    .alloc_cell_id(alloc_cell_id), .alloc_mem_success(alloc_mem_success),
    .alloc_mem_intense(alloc_mem_intense),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_cell_id(m_desc_cell_id), .m_desc_len(m_desc_len),
    .s_rel_valid(s_rel_valid), .s_rel_ready(s_rel_ready),
    .s_rel_cell_id(s_rel_cell_id), .s_rel_len(s_rel_len),
    .free_mem_req(free_mem_req), .free_mem_ready(free_mem_ready),
    .free_cell_id(free_cell_id), .free_mem_size(free_mem_size),
    .drop_cnt(drop_cnt), .alloc_cnt(alloc_cnt),
    .outstanding_cells(outstanding_cells)
  );

  always #5 clk = ~clk;

  // Hard stop in case some wait below never resolves.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare the three statistics outputs against the model.
  task automatic check_stats(input string tag);
    checks++;
    if (drop_cnt !== 32'(drop_m)) begin
      failures++;
      $display("[TB] FAIL %s drop_cnt got=%0d exp=%0d", tag, drop_cnt, drop_m);
    end
    checks++;
    if (alloc_cnt !== 32'(alloc_m)) begin
      failures++;
      $display("[TB] FAIL %s alloc_cnt got=%0d exp=%0d", tag, alloc_cnt, alloc_m);
    end
    checks++;
    if (outstanding_cells !== 7'(occ_m)) begin
      failures++;
      $display("[TB] FAIL %s outstanding got=%0d exp=%0d", tag, outstanding_cells, occ_m);
    end
  endtask

  // One packet from offer to drop or descriptor handshake; success comes on request number succ_at.
  task automatic send_pkt(input int len, input bit prio, input bit intense,
                          input int succ_at, input logic [5:0] id, input string tag);
    bit bad;
    bit exp_alloc;
    int exp_req;
    int exp_k;
    int reqs;
    int k;
    bad       = (len == 0) || (len > 1536) || (intense && !prio);
    exp_alloc = !bad && (succ_at < 8);
    exp_req   = bad ? 0 : ((succ_at < 8) ? succ_at + 1 : 8);
    exp_k     = bad ? 2 : exp_req + 1;
    @(negedge clk);
    s_pkt_valid = 1'b1;
    s_pkt_len = 16'(len);
    s_pkt_prio = prio;
    alloc_mem_intense = intense;
    #1;
    checks++;
    if (s_pkt_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s accept_ready got=%b exp=1", tag, s_pkt_ready);
    end
    @(negedge clk);
    s_pkt_valid = 1'b0;
    reqs = 0;
    k = 1;
    while (k <= 20) begin
      #1;
      if (m_desc_valid === 1'b1 || s_pkt_ready === 1'b1) break;
      if (alloc_mem_req === 1'b1) begin
        checks++;
        if (alloc_mem_size !== 16'(len)) begin
          failures++;
          $display("[TB] FAIL %s req_size got=%0d exp=%0d", tag, alloc_mem_size, len);
        end
        alloc_mem_success = (reqs == succ_at);
        alloc_cell_id = id;
        reqs++;
      end
      @(negedge clk);
      alloc_mem_success = 1'b0;
      k++;
    end
    checks++;
    if (k > 20) begin
      failures++;
      $display("[TB] FAIL %s completion timed out after %0d cycles exp=%0d", tag, k, exp_k);
    end else if (k != exp_k) begin
      failures++;
      $display("[TB] FAIL %s completion_cycle got=%0d exp=%0d", tag, k, exp_k);
    end
    checks++;
    if (reqs != exp_req) begin
      failures++;
      $display("[TB] FAIL %s req_cycles got=%0d exp=%0d", tag, reqs, exp_req);
    end
    checks++;
    if (m_desc_valid !== exp_alloc) begin
      failures++;
      $display("[TB] FAIL %s desc_valid got=%b exp=%b", tag, m_desc_valid, exp_alloc);
    end
    if (exp_alloc && m_desc_valid === 1'b1) begin
      int stall;
      stall = $urandom_range(0, 2);
      for (int s = 0; s <= stall; s++) begin
        checks++;
        if (m_desc_cell_id !== id || m_desc_len !== 16'(len)) begin
          failures++;
          $display("[TB] FAIL %s desc_fields got=%0d/%0d exp=%0d/%0d", tag,
                   m_desc_cell_id, m_desc_len, id, len);
        end
        if (s < stall) begin
          @(negedge clk);
          #1;
        end
      end
      m_desc_ready = 1'b1;
      @(negedge clk);
      m_desc_ready = 1'b0;
      #1;
      checks++;
      if (m_desc_valid !== 1'b0 || s_pkt_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL %s after_handshake valid=%b ready=%b exp valid=0 ready=1", tag,
                 m_desc_valid, s_pkt_ready);
      end
    end
    if (bad || !exp_alloc) drop_m++;
    else begin
      alloc_m++;
      if (occ_m < 64) occ_m++;
    end
    alloc_mem_intense = 1'b0;
    check_stats(tag);
  endtask

  // One release-path cycle: drive, check against the queue model, then book the next edge.
  task automatic rel_cycle(input bit valid, input logic [5:0] id, input logic [15:0] len,
                           input bit fready, output bit accepted);
    int sz;
    @(negedge clk);
    s_rel_valid = valid;
    s_rel_cell_id = id;
    s_rel_len = len;
    free_mem_ready = fready;
    #1;
    sz = rel_q.size();
    checks++;
    if (s_rel_ready !== (sz < 4)) begin
      failures++;
      $display("[TB] FAIL rel_ready got=%b exp=%b depth=%0d", s_rel_ready, (sz < 4), sz);
    end
    checks++;
    if (free_mem_req !== (sz > 0)) begin
      failures++;
      $display("[TB] FAIL free_req got=%b exp=%b", free_mem_req, (sz > 0));
    end
    if (sz > 0) begin
      checks++;
      if ({free_mem_size, free_cell_id} !== rel_q[0]) begin
        failures++;
        $display("[TB] FAIL free_head got=%0d/%0d exp=%0d/%0d", free_cell_id, free_mem_size,
                 rel_q[0][5:0], rel_q[0][21:6]);
      end
    end
    accepted = valid && (sz < 4);
    if (fready && sz > 0) begin
      void'(rel_q.pop_front());
      if (occ_m > 0) occ_m--;
    end
    if (accepted) rel_q.push_back({len, id});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_pkt_ready, alloc_mem_req, m_desc_valid, s_rel_ready, free_mem_req} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b exp=00000",
               {s_pkt_ready, alloc_mem_req, m_desc_valid, s_rel_ready, free_mem_req});
    end
    check_stats("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (s_pkt_ready !== 1'b1 || s_rel_ready !== 1'b1 || free_mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL post_reset got ready=%b rel_ready=%b free_req=%b exp 1/1/0",
               s_pkt_ready, s_rel_ready, free_mem_req);
    end
  endtask

  task automatic test_basic();
    send_pkt(64, 1'b0, 1'b0, 0, 6'd5, "basic_64");
    send_pkt(900, 1'b1, 1'b0, 3, 6'd17, "basic_retry3");
  endtask

  task automatic test_length_bounds();
    send_pkt(2000, 1'b0, 1'b0, 0, 6'd1, "len_2000");
    send_pkt(0, 1'b1, 1'b0, 0, 6'd2, "len_0");
    send_pkt(1537, 1'b1, 1'b0, 0, 6'd3, "len_1537");
    send_pkt(1536, 1'b0, 1'b0, 0, 6'd4, "len_1536");
    send_pkt(1, 1'b0, 1'b0, 1, 6'd63, "len_1");
  endtask

  task automatic test_intense();
    send_pkt(200, 1'b0, 1'b1, 0, 6'd8, "intense_lo");
    send_pkt(200, 1'b1, 1'b1, 0, 6'd7, "intense_hi");
  endtask

  task automatic test_timeout();
    send_pkt(100, 1'b1, 1'b0, 99, 6'd9, "timeout");
    send_pkt(100, 1'b0, 1'b0, 7, 6'd10, "last_retry");
  endtask

  task automatic test_release();
    logic [5:0]  ids [5];
    logic [15:0] lens[5];
    int occ_before;
    bit acc;
    bit pending;
    int n;
    for (int i = 0; i < 6; i++) send_pkt(100 + i, 1'b1, 1'b0, 0, 6'(20 + i), "rel_prefill");
    occ_before = occ_m;
    for (int i = 0; i < 5; i++) begin
      ids[i]  = 6'($urandom_range(0, 63));
      lens[i] = 16'($urandom_range(1, 1536));
    end
    for (int i = 0; i < 5; i++) rel_cycle(1'b1, ids[i], lens[i], 1'b0, acc);
    for (int i = 0; i < 2; i++) rel_cycle(1'b0, 6'd0, 16'd0, 1'b0, acc);
    pending = 1'b1;
    n = 0;
    while ((pending || rel_q.size() > 0) && n < 20) begin
      rel_cycle(pending, ids[4], lens[4], 1'b1, acc);
      if (acc) pending = 1'b0;
      n++;
    end
    @(negedge clk);
    s_rel_valid = 1'b0;
    free_mem_ready = 1'b0;
    #1;
    checks++;
    if (n >= 20 || outstanding_cells !== 7'(occ_before - 5)) begin
      failures++;
      $display("[TB] FAIL release_drain outstanding got=%0d exp=%0d loops=%0d",
               outstanding_cells, occ_before - 5, n);
    end
    check_stats("release");
  endtask

  task automatic test_simultaneous();
    bit acc;
    int occ_prev;
    rel_cycle(1'b1, 6'd33, 16'd77, 1'b0, acc);
    @(negedge clk);
    s_rel_valid = 1'b0;
    s_pkt_valid = 1'b1;
    s_pkt_len = 16'd300;
    s_pkt_prio = 1'b1;
    @(negedge clk);
    s_pkt_valid = 1'b0;
    #1;
    checks++;
    if (alloc_mem_req !== 1'b1 || free_mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simul_setup req=%b free_req=%b exp 1/1", alloc_mem_req, free_mem_req);
    end
    occ_prev = occ_m;
    alloc_mem_success = 1'b1;
    alloc_cell_id = 6'd9;
    free_mem_ready = 1'b1;
    @(negedge clk);
    alloc_mem_success = 1'b0;
    free_mem_ready = 1'b0;
    void'(rel_q.pop_front());
    alloc_m++;
    #1;
    checks++;
    if (outstanding_cells !== 7'(occ_prev)) begin
      failures++;
      $display("[TB] FAIL simul_outstanding got=%0d exp=%0d", outstanding_cells, occ_prev);
    end
    checks++;
    if (m_desc_valid !== 1'b1 || m_desc_cell_id !== 6'd9 || free_mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_desc valid=%b id=%0d free_req=%b exp 1/9/0",
               m_desc_valid, m_desc_cell_id, free_mem_req);
    end
    m_desc_ready = 1'b1;
    @(negedge clk);
    m_desc_ready = 1'b0;
    #1;
    check_stats("simultaneous");
  endtask

  task automatic test_random();
    int len;
    int sel;
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) len = 0;
      else if (sel == 1) len = $urandom_range(1537, 65535);
      else if (sel == 2) len = 1536;
      else len = $urandom_range(1, 1536);
      send_pkt(len, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               $urandom_range(0, 10), 6'($urandom_range(0, 63)), "random");
    end
  endtask

  task automatic test_reset_during_out();
    @(negedge clk);
    s_pkt_valid = 1'b1;
    s_pkt_len = 16'd500;
    s_pkt_prio = 1'b1;
    @(negedge clk);
    s_pkt_valid = 1'b0;
    alloc_mem_success = 1'b1;
    alloc_cell_id = 6'd44;
    @(negedge clk);
    alloc_mem_success = 1'b0;
    #1;
    checks++;
    if (m_desc_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_out_setup desc_valid got=%b exp=1", m_desc_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (m_desc_valid !== 1'b0 || m_desc_cell_id !== 6'd0) begin
      failures++;
      $display("[TB] FAIL rst_out_during valid=%b id=%0d exp 0/0", m_desc_valid, m_desc_cell_id);
    end
    @(negedge clk);
    #1;
    drop_m = 0;
    alloc_m = 0;
    occ_m = 0;
    rel_q.delete();
    checks++;
    if (m_desc_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_out_next desc_valid got=%b exp=0", m_desc_valid);
    end
    check_stats("rst_out_held");
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (s_pkt_ready !== 1'b1 || m_desc_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_out_release ready=%b valid=%b exp 1/0", s_pkt_ready, m_desc_valid);
    end
    check_stats("rst_out_after");
  endtask

  // Scenario sequence; each task checks its own observations.
  initial begin
    test_reset();
    test_basic();
    test_length_bounds();
    test_intense();
    test_timeout();
    test_release();
    test_simultaneous();
    test_random();
    test_reset_during_out();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
